ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch unit sitting directly upstream of the IFU/IDU pipeline register. It owns the PC and issues one outstanding AXI4-Lite read per instruction. It presents {pc, inst} to the decode-side register via a valid/ready handshake; the register's write enable is valid_o & ready_i. It also accepts control-flow redirects from later stages.

Parameters:
ADDR_W, 32, PC / AXI address width
DATA_W, 32, instruction / AXI read data width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  synchronous reset, active-high
redirect_valid_i  in  1  redirect request from later stage (branch/jump/trap)
redirect_pc_i  in  ADDR_W  redirect target; bits [1:0] ignored, forced to 0
arvalid_o  out  1  AXI AR valid
arready_i  in  1  AXI AR ready
araddr_o  out  ADDR_W  AXI AR address (= fetch PC)
rvalid_i  in  1  AXI R valid
rready_o  out  1  AXI R ready
rdata_i  in  DATA_W  AXI R data
rresp_i  in  2  AXI R response
valid_o  out  1  fetched instruction valid toward decode register
ready_i  in  1  decode register can accept
pc_o  out  ADDR_W  PC of presented instruction
inst_o  out  DATA_W  presented instruction
fault_o  out  1  access fault for presented instruction (rresp != OKAY); qualified by valid_o

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; pc=RESET_PC; arvalid_o=0; rready_o=0; valid_o=0; inst_o=0; fault_o=0; drop=0. pc_o and araddr_o are driven from the pc register, so both read RESET_PC.
- A reset mid-transaction abandons it. The slave is reset on the same rst.
- FSM states:
  - IDLE: all handshakes low; next state AR unconditionally.
  - AR: arvalid_o=1, araddr_o=pc. On arready_i -> R.
  - R: rready_o=1. On rvalid_i:
    - drop=1: discard the beat, clear drop -> AR.
    - drop=0: inst<=rdata_i, fault<=(rresp_i!=2'b00) -> OUT.
  - OUT: valid_o=1; pc_o, inst_o and fault_o are held stable. On ready_i: pc<=pc+4 (wraps modulo 2^ADDR_W) -> AR.
- Timing with a zero-wait slave: AR handshake in cycle N, rvalid earliest N+1, valid_o in N+2. Throughput is 1 instruction per 3 cycles; only one AR is ever outstanding.
- AXI rule: once arvalid_o is asserted, araddr_o stays stable until arready_i. A redirect never alters an in-flight AR.
- Redirect (redirect_valid_i=1, highest priority; pc<=redirect_pc_i & ~3 in all cases):
  - IDLE or OUT: next state AR; valid_o deasserts the next cycle. If ready_i coincides in OUT, the handshake still completes (decode captures the old instruction) but the next PC is the redirect target, not pc+4.
  - AR: the current AR stays pending with its old address (araddr_o is driven from a latched request address, not from pc); drop<=1; the new PC takes effect on the next AR. If arready_i coincides, go to R with drop=1.
  - R: drop<=1. If rvalid_i coincides, that beat is discarded and the next state is AR with the new PC.
  - Multiple redirects before the dropped response returns: the last target wins; only one response is dropped.
- rresp_i SLVERR/DECERR: the instruction is still presented, with fault_o=1, and the PC advances normally on handshake. Trap handling is a later stage's job.
- No combinational path from any input to arvalid_o, rready_o or valid_o. Outputs are registered, state-decoded only.

Decomposition:
- Shared defines/package: RESET_PC, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, and the fetch-state encodings (IDLE/AR/R/OUT).
- One sub-module, ifu_pc_gen: holds pc and the latched request address, and applies pc+4 / redirect / reset priority.
- The FSM and output registers stay in ifu_fetch.

Test Plan:
- Reset release, zero-wait slave returning 32'h0000_0013 -> AR at 0x8000_0000; valid_o two cycles after AR handshake; pc_o=0x8000_0000, inst_o=0x13; next AR at 0x8000_0004.
- ready_i held low 5 cycles in OUT -> valid_o, pc_o and inst_o stable all 5 cycles, no new AR; after ready_i=1, AR at pc+4.
- Redirect to 0x8000_0103 while in R, response arrives 2 cycles later -> that response is discarded (valid_o stays 0); next AR at 0x8000_0100.
- Redirect while arvalid_o=1 and arready_i held low 3 cycles -> araddr_o unchanged until the handshake; response dropped; following AR uses the redirect target.
- rresp_i=2'b10 with rdata 0xDEADBEEF -> valid_o=1, fault_o=1, inst_o=0xDEADBEEF; PC advances +4 on handshake.
- Redirect and ready_i in the same OUT cycle at pc 0x8000_0010, target 0x8000_0200 -> handshake counted; next AR at 0x8000_0200, not 0x8000_0014.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared constants and state encodings for the instruction fetch unit.
package ifu_fetch_pkg;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_OUT
   } fetch_state_e;

endpackage

// File: rtl/ifu_pc_gen.sv
// PC register and latched AR request address.
// Priority: reset, then redirect, then sequential advance.
module ifu_pc_gen #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              advance,
   input  logic              load_req,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] req_addr
);

   logic [ADDR_W-1:0] pc_next;

   always_comb begin
      pc_next = pc;
      if (redirect_valid)
         pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (advance)
         pc_next = pc + ADDR_W'(4);
   end

   // req_addr samples the PC being issued so a redirect
   // cannot disturb an AR that is already pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         pc <= pc_next;
         if (load_req)
            req_addr <= pc_next;
      end
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding AXI4-Lite read per instruction,
// valid/ready toward the IFU/IDU register, redirect with response drop.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ifu_fetch_pkg::RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              arvalid_o,
   input  logic              arready_i,
   output logic [ADDR_W-1:0] araddr_o,
   input  logic              rvalid_i,
   output logic              rready_o,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        rresp_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] inst_o,
   output logic              fault_o
);

   fetch_state_e      state, state_next;
   logic              drop, drop_next;
   logic              capture, advance, load_req;
   logic [DATA_W-1:0] inst;
   logic              fault;
   logic [ADDR_W-1:0] pc, req_addr;

   always_comb begin
      state_next = state;
      drop_next  = drop;
      unique case (state)
         ST_IDLE: state_next = ST_AR;
         ST_AR: begin
            if (arready_i)
               state_next = ST_R;
            if (redirect_valid_i)
               drop_next = 1'b1;
         end
         ST_R: begin
            // A beat arriving with a redirect is the stale one itself,
            // so it is consumed here and nothing is left to drop.
            if (rvalid_i) begin
               drop_next  = 1'b0;
               state_next = (drop || redirect_valid_i) ? ST_AR : ST_OUT;
            end else if (redirect_valid_i) begin
               drop_next = 1'b1;
            end
         end
         ST_OUT: begin
            if (ready_i || redirect_valid_i)
               state_next = ST_AR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign capture  = (state == ST_R) && rvalid_i
                     && !drop && !redirect_valid_i;
   assign advance  = (state == ST_OUT) && ready_i;
   assign load_req = (state_next == ST_AR) && (state != ST_AR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         drop  <= 1'b0;
         inst  <= '0;
         fault <= 1'b0;
      end else begin
         state <= state_next;
         drop  <= drop_next;
         if (capture) begin
            inst  <= rdata_i;
            fault <= (rresp_i != AXI_RESP_OKAY);
         end
      end
   end

   ifu_pc_gen #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_pc_gen (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid_i),
      .redirect_pc    (redirect_pc_i),
      .advance        (advance),
      .load_req       (load_req),
      .pc             (pc),
      .req_addr       (req_addr)
   );

   assign arvalid_o = (state == ST_AR);
   assign rready_o  = (state == ST_R);
   assign valid_o   = (state == ST_OUT);
   assign araddr_o  = req_addr;
   assign pc_o      = pc;
   assign inst_o    = inst;
   assign fault_o   = fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: table of fetches plus redirect sequences.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        arvalid_o;
   logic        arready_i;
   logic [31:0] araddr_o;
   logic        rvalid_i;
   logic        rready_o;
   logic [31:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        fault_o;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        fault;
      int          ar_wait;
      int          hold;
      logic        redir;
      logic [31:0] tgt;
   } vec_t;

   vec_t vecs[6];
   vec_t v;

   ifu_fetch dut (
      .clk              (clk),
      .rst              (rst),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .arvalid_o        (arvalid_o),
      .arready_i        (arready_i),
      .araddr_o         (araddr_o),
      .rvalid_i         (rvalid_i),
      .rready_o         (rready_o),
      .rdata_i          (rdata_i),
      .rresp_i          (rresp_i),
      .valid_o          (valid_o),
      .ready_i          (ready_i),
      .pc_o             (pc_o),
      .inst_o           (inst_o),
      .fault_o          (fault_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wait_ar(input logic [31:0] addr);
      int n = 0;
      while (!arvalid_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ar_seen", 64'(arvalid_o), 64'd1);
      chk("araddr", 64'(araddr_o), 64'(addr));
   endtask

   task automatic ar_hs();
      arready_i = 1'b1;
      @(negedge clk);
      arready_i = 1'b0;
      chk("rready_in_r", 64'(rready_o), 64'd1);
      chk("valid_in_r", 64'(valid_o), 64'd0);
   endtask

   task automatic r_beat(input logic [31:0] d, input logic [1:0] r);
      rvalid_i = 1'b1;
      rdata_i  = d;
      rresp_i  = r;
      @(negedge clk);
      rvalid_i = 1'b0;
      rdata_i  = '0;
      rresp_i  = '0;
   endtask

   task automatic fetch(input vec_t x);
      wait_ar(x.addr);
      for (int i = 0; i < x.ar_wait; i++) begin
         @(negedge clk);
         chk("ar_hold_valid", 64'(arvalid_o), 64'd1);
         chk("ar_hold_addr", 64'(araddr_o), 64'(x.addr));
      end
      ar_hs();
      r_beat(x.data, x.resp);
      chk("valid", 64'(valid_o), 64'd1);
      chk("pc", 64'(pc_o), 64'(x.addr));
      chk("inst", 64'(inst_o), 64'(x.data));
      chk("fault", 64'(fault_o), 64'(x.fault));
      for (int i = 0; i < x.hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(valid_o), 64'd1);
         chk("hold_pc", 64'(pc_o), 64'(x.addr));
         chk("hold_inst", 64'(inst_o), 64'(x.data));
         chk("hold_no_ar", 64'(arvalid_o), 64'd0);
      end
      ready_i          = 1'b1;
      redirect_valid_i = x.redir;
      redirect_pc_i    = x.tgt;
      @(negedge clk);
      ready_i          = 1'b0;
      redirect_valid_i = 1'b0;
      chk("valid_after_hs", 64'(valid_o), 64'd0);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d);
      vec_t r;
      r = '{a, d, 2'b00, 1'b0, 0, 0, 1'b0, 32'h0};
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: got no end, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{32'h8000_0000, 32'h0000_0013, 2'b00, 1'b0, 0, 0, 1'b0, 32'h0};
      vecs[1] = '{32'h8000_0004, 32'h0010_0093, 2'b00, 1'b0, 0, 5, 1'b0, 32'h0};
      vecs[2] = '{32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 1'b1, 0, 0, 1'b0, 32'h0};
      vecs[3] = '{32'h8000_000C, 32'h1234_5678, 2'b11, 1'b1, 2, 1, 1'b0, 32'h0};
      vecs[4] = '{32'h8000_0010, 32'h0000_0073, 2'b00, 1'b0, 0, 0, 1'b1,
                  32'h8000_0200};
      vecs[5] = '{32'h8000_0200, 32'h0000_0513, 2'b00, 1'b0, 1, 0, 1'b0, 32'h0};

      rst              = 1'b1;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
      arready_i        = 1'b0;
      rvalid_i         = 1'b0;
      rdata_i          = '0;
      rresp_i          = '0;
      ready_i          = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_arvalid", 64'(arvalid_o), 64'd0);
      chk("rst_rready", 64'(rready_o), 64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_pc", 64'(pc_o), 64'h8000_0000);
      chk("rst_araddr", 64'(araddr_o), 64'h8000_0000);
      chk("rst_inst", 64'(inst_o), 64'd0);
      chk("rst_fault", 64'(fault_o), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_first", 64'(arvalid_o), 64'd1);

      foreach (vecs[i]) fetch(vecs[i]);

      // redirect while in R, stale beat two cycles later
      wait_ar(32'h8000_0204);
      ar_hs();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0103;
      @(negedge clk);
      redirect_valid_i = 1'b0;
      @(negedge clk);
      chk("r_redir_wait", 64'(valid_o), 64'd0);
      r_beat(32'hBAD0_BAD0, 2'b00);
      chk("r_redir_drop", 64'(valid_o), 64'd0);
      v = mk(32'h8000_0100, 32'h0020_0113);
      fetch(v);

      // redirect while AR is stalled
      wait_ar(32'h8000_0104);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0400;
      @(negedge clk);
      redirect_valid_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("ar_redir_valid", 64'(arvalid_o), 64'd1);
         chk("ar_redir_addr", 64'(araddr_o), 64'h8000_0104);
         @(negedge clk);
      end
      chk("ar_redir_addr3", 64'(araddr_o), 64'h8000_0104);
      ar_hs();
      r_beat(32'hBAD1_BAD1, 2'b00);
      chk("ar_redir_drop", 64'(valid_o), 64'd0);
      v = mk(32'h8000_0400, 32'h0030_0193);
      fetch(v);

      // redirect coinciding with the response: only that beat dropped
      wait_ar(32'h8000_0404);
      ar_hs();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h8000_0601;
      r_beat(32'hBAD2_BAD2, 2'b00);
      redirect_valid_i = 1'b0;
      chk("rv_redir_drop", 64'(valid_o), 64'd0);
      v = mk(32'h8000_0600, 32'h0040_0213);
      fetch(v);
      wait_ar(32'h8000_0604);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
